// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver with 2-of-3 bit vote and valid/ready output.
// Parity checking is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 baud_sample_6th,
  input  logic                 baud_sample_8th,
  input  logic                 baud_sample_10th,
  input  logic                 baud_sample_16th,
`ifdef UART_RX_PARITY_EN
  input  logic                 cfg_parity_en,
  input  logic                 cfg_parity_odd,
`endif
  output logic                 baud_clear,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  state_t               r_state;
  logic                 r_sync1, r_sync2, r_prev;
  logic [1:0]           r_warm;
  logic                 r_v6, r_v8;
  logic [2:0]           r_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_fall, w_bit, w_done, w_par_en, w_perr;

  assign w_fall     = r_prev & ~r_sync2;
  assign w_bit      = (r_v6 & r_v8) | (r_v6 & r_sync2) | (r_v8 & r_sync2);
  assign w_done     = (r_state == S_STOP) & baud_sample_10th;
  assign baud_clear = (r_state == S_IDLE) & w_fall;
  assign rx_busy    = r_state != S_IDLE;

  // r_warm keeps the reset-time highs of the synchronizer from looking like a real idle line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b0;
      r_warm  <= 2'b00;
      r_v6    <= 1'b0;
      r_v8    <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_warm  <= {r_warm[0], 1'b1};
      r_prev  <= r_sync2 & r_warm[1];
      if (baud_sample_6th) r_v6 <= r_sync2;
      if (baud_sample_8th) r_v8 <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_shift <= '0;
    end else begin
      case (r_state)
        S_IDLE:   if (w_fall) r_state <= S_START;
        S_START:  if (baud_sample_10th && w_bit) r_state <= S_IDLE;
                  else if (baud_sample_16th) begin
                    r_state <= S_DATA;
                    r_cnt   <= 3'd0;
                  end
        S_DATA: begin
          if (baud_sample_10th) r_shift[r_cnt] <= w_bit;
          if (baud_sample_16th) begin
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'(DATA_BITS - 1)) r_state <= w_par_en ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: if (baud_sample_16th) r_state <= S_STOP;
        S_STOP:   if (baud_sample_10th) r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_en, r_par_odd, r_par;
  assign w_par_en = r_par_en;
  assign w_perr   = r_par_en & (^{r_shift, r_par} ^ r_par_odd);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
      r_par     <= 1'b0;
    end else begin
      if (baud_clear) begin
        r_par_en  <= cfg_parity_en;
        r_par_odd <= cfg_parity_odd;
      end
      if (r_state == S_PARITY && baud_sample_10th) r_par <= w_bit;
    end
  end
`else
  assign w_par_en = 1'b0;
  assign w_perr   = 1'b0;
`endif

  // a completion always loads; an unconsumed word being replaced flags overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= w_done & rx_valid & ~rx_ready;
      if (w_done) begin
        rx_data       <= r_shift;
        rx_frame_err  <= ~w_bit;
        rx_parity_err <= w_perr;
        rx_valid      <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a 16 clk/sample baud model.
`timescale 1ns/1ps
module tb_uart_rx;
  logic       clk = 1'b0, rst_n = 1'b0, rx = 1'b1, rx_ready = 1'b1;
  logic       b6, b8, b10, b16, baud_clear;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_parity_err, rx_overrun, rx_busy;
  logic [7:0] bcnt = 8'd0;
  int         n_cmp = 0, n_err = 0;
  int         n_clr = 0, n_vcyc = 0, n_ovr = 0;
  logic [7:0] last_data = 8'd0;
  logic       last_fe = 1'b0, last_pe = 1'b0;
  int         c_clr, c_vcyc, c_ovr;
`ifdef UART_RX_PARITY_EN
  logic       cfg_parity_en = 1'b0, cfg_parity_odd = 1'b0;
`endif

  always #5 clk = ~clk;

  // baud generator model: 16 clocks per sample, 256 per bit, restarted by baud_clear
  always @(posedge clk) bcnt <= baud_clear ? 8'd0 : bcnt + 8'd1;
  assign b6  = bcnt == 8'd95;
  assign b8  = bcnt == 8'd127;
  assign b10 = bcnt == 8'd159;
  assign b16 = bcnt == 8'd255;

  uart_rx #(.DATA_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .baud_sample_6th(b6), .baud_sample_8th(b8),
    .baud_sample_10th(b10), .baud_sample_16th(b16),
`ifdef UART_RX_PARITY_EN
    .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
`endif
    .baud_clear(baud_clear), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_frame_err(rx_frame_err),
    .rx_parity_err(rx_parity_err), .rx_overrun(rx_overrun), .rx_busy(rx_busy)
  );

  always @(negedge clk) begin
    if (baud_clear) n_clr++;
    if (rx_overrun) n_ovr++;
    if (rx_valid) begin
      n_vcyc++;
      last_data = rx_data;
      last_fe   = rx_frame_err;
      last_pe   = rx_parity_err;
    end
  end

  task automatic snap();
    c_clr = n_clr; c_vcyc = n_vcyc; c_ovr = n_ovr;
  endtask

  // f[0] goes out first; gb selects a data bit whose 8th sample is inverted
  task automatic send_raw(input logic [10:0] f, input int nb, input int gb);
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < 256; c++) begin
        @(negedge clk);
        rx = f[b] ^ (b == gb + 1 && c >= 120 && c < 136);
      end
  endtask

  task automatic idle(input int n, input logic v);
    repeat (n) begin @(negedge clk); rx = v; end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", rx_valid); end
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", rx_data); end
    n_cmp++; if (rx_frame_err !== 1'b0) begin n_err++; $display("FAIL rst_fe: got %b want 0", rx_frame_err); end
    n_cmp++; if (rx_parity_err !== 1'b0) begin n_err++; $display("FAIL rst_pe: got %b want 0", rx_parity_err); end
    n_cmp++; if (rx_overrun !== 1'b0) begin n_err++; $display("FAIL rst_ovr: got %b want 0", rx_overrun); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", rx_busy); end
    n_cmp++; if (baud_clear !== 1'b0) begin n_err++; $display("FAIL rst_clear: got %b want 0", baud_clear); end
    rst_n = 1'b1;
    idle(20, 1'b1);
  endtask

  task automatic test_basic();
    snap();
    send_raw({2'b11, 8'hA5, 1'b0}, 10, -5);
    idle(20, 1'b1);
    n_cmp++; if (n_vcyc - c_vcyc !== 1) begin n_err++; $display("FAIL basic_valid_cycles: got %0d want 1", n_vcyc - c_vcyc); end
    n_cmp++; if (last_data !== 8'hA5) begin n_err++; $display("FAIL basic_data: got %h want a5", last_data); end
    n_cmp++; if (last_fe !== 1'b0) begin n_err++; $display("FAIL basic_fe: got %b want 0", last_fe); end
    n_cmp++; if (last_pe !== 1'b0) begin n_err++; $display("FAIL basic_pe: got %b want 0", last_pe); end
    n_cmp++; if (n_clr - c_clr !== 1) begin n_err++; $display("FAIL basic_clears: got %0d want 1", n_clr - c_clr); end
    n_cmp++; if (n_ovr - c_ovr !== 0) begin n_err++; $display("FAIL basic_ovr: got %0d want 0", n_ovr - c_ovr); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL basic_busy: got %b want 0", rx_busy); end
  endtask

  task automatic test_false_start();
    snap();
    idle(48, 1'b0);
    n_cmp++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL fstart_busy_mid: got %b want 1", rx_busy); end
    idle(152, 1'b1);
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL fstart_busy_after10: got %b want 0", rx_busy); end
    idle(300, 1'b1);
    n_cmp++; if (n_clr - c_clr !== 1) begin n_err++; $display("FAIL fstart_clears: got %0d want 1", n_clr - c_clr); end
    n_cmp++; if (n_vcyc - c_vcyc !== 0) begin n_err++; $display("FAIL fstart_valid: got %0d want 0", n_vcyc - c_vcyc); end
  endtask

  task automatic test_vote();
    snap();
    send_raw({2'b11, 8'h3C, 1'b0}, 10, 2);
    idle(20, 1'b1);
    n_cmp++; if (last_data !== 8'h3C) begin n_err++; $display("FAIL vote_data: got %h want 3c", last_data); end
    n_cmp++; if (last_fe !== 1'b0) begin n_err++; $display("FAIL vote_fe: got %b want 0", last_fe); end
    n_cmp++; if (n_vcyc - c_vcyc !== 1) begin n_err++; $display("FAIL vote_valid: got %0d want 1", n_vcyc - c_vcyc); end
  endtask

  task automatic test_framing();
    snap();
    send_raw({2'b00, 8'h55, 1'b0}, 10, -5);
    idle(600, 1'b0);
    n_cmp++; if (last_fe !== 1'b1) begin n_err++; $display("FAIL frame_fe: got %b want 1", last_fe); end
    n_cmp++; if (last_data !== 8'h55) begin n_err++; $display("FAIL frame_data: got %h want 55", last_data); end
    n_cmp++; if (n_clr - c_clr !== 1) begin n_err++; $display("FAIL frame_break_clears: got %0d want 1", n_clr - c_clr); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL frame_break_busy: got %b want 0", rx_busy); end
    idle(300, 1'b1);
    send_raw({2'b11, 8'h81, 1'b0}, 10, -5);
    idle(20, 1'b1);
    n_cmp++; if (n_clr - c_clr !== 2) begin n_err++; $display("FAIL frame_resync_clears: got %0d want 2", n_clr - c_clr); end
    n_cmp++; if (last_data !== 8'h81) begin n_err++; $display("FAIL frame_resync_data: got %h want 81", last_data); end
    n_cmp++; if (last_fe !== 1'b0) begin n_err++; $display("FAIL frame_resync_fe: got %b want 0", last_fe); end
  endtask

  task automatic test_overrun();
    snap();
    rx_ready = 1'b0;
    send_raw({2'b11, 8'h11, 1'b0}, 10, -5);
    n_cmp++; if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin n_err++; $display("FAIL ovr_first: got %h/%b want 11/1", rx_data, rx_valid); end
    send_raw({2'b11, 8'h22, 1'b0}, 10, -5);
    idle(5, 1'b1);
    n_cmp++; if (n_ovr - c_ovr !== 1) begin n_err++; $display("FAIL ovr_pulses: got %0d want 1", n_ovr - c_ovr); end
    n_cmp++; if (rx_data !== 8'h22) begin n_err++; $display("FAIL ovr_data: got %h want 22", rx_data); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid_held: got %b want 1", rx_valid); end
    rx_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL ovr_consume: got %b want 0", rx_valid); end
  endtask

  task automatic test_reset_midframe();
    rx_ready = 1'b0;
    send_raw({2'b11, 8'h5A, 1'b0}, 10, -5);
    idle(1408, 1'b0);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", rx_valid); end
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL rmid_data: got %h want 00", rx_data); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", rx_busy); end
    n_cmp++; if (rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) begin n_err++; $display("FAIL rmid_flags: got %b%b want 00", rx_frame_err, rx_overrun); end
    idle(4, 1'b0);
    rst_n = 1'b1;
    snap();
    idle(600, 1'b0);
    n_cmp++; if (n_clr - c_clr !== 0) begin n_err++; $display("FAIL rmid_low_clears: got %0d want 0", n_clr - c_clr); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL rmid_low_busy: got %b want 0", rx_busy); end
    idle(300, 1'b1);
    rx_ready = 1'b1;
    send_raw({2'b11, 8'h96, 1'b0}, 10, -5);
    idle(20, 1'b1);
    n_cmp++; if (n_clr - c_clr !== 1) begin n_err++; $display("FAIL rmid_resync_clears: got %0d want 1", n_clr - c_clr); end
    n_cmp++; if (last_data !== 8'h96) begin n_err++; $display("FAIL rmid_resync_data: got %h want 96", last_data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    cfg_parity_en = 1'b1;
    cfg_parity_odd = 1'b0;
    send_raw({1'b1, 1'b1, 8'h07, 1'b0}, 11, -5);
    idle(20, 1'b1);
    n_cmp++; if (last_data !== 8'h07 || last_pe !== 1'b0) begin n_err++; $display("FAIL par_good: got %h/%b want 07/0", last_data, last_pe); end
    send_raw({1'b1, 1'b0, 8'h07, 1'b0}, 11, -5);
    idle(20, 1'b1);
    n_cmp++; if (last_data !== 8'h07 || last_pe !== 1'b1) begin n_err++; $display("FAIL par_bad: got %h/%b want 07/1", last_data, last_pe); end
    cfg_parity_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_vote();
    test_framing();
    test_overrun();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
